// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO, gated by a synchronised CTS.
// Frames are launched back-to-back straight from the stop bit while data is queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               cts_i,
    output logic               tx_o,
    output logic               busy_o,
    output logic [FIFO_AW:0]   level_o
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               pop;
    logic               can_pop;
    logic               bit_end;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ready_q;
    logic               wr_en;

    logic               cts_meta, cts_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            cts_meta <= cts_i;
            cts_s    <= cts_meta;
        end
    end

    // A pop on the same edge frees a slot, so a write is taken even when full.
    assign wr_en = valid_i && (ready_q || pop);

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            level_q <= level_d;
            ready_q <= (level_d != LEVEL_FULL);
        end
    end

    assign can_pop = (level_q != '0) && cts_s;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (can_pop) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed for the upcoming state so tx_o comes straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = (state_q != IDLE);
    assign ready_o = ready_q;
    assign level_o = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line monitor decoding 8N1 frames plus
// directed timing/flow-control sequences and randomized byte streams.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
    localparam int AW       = 4;
    localparam int DEPTH    = 2 ** AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_o;
    logic          cts_i;
    logic          tx_o;
    logic          busy_o;
    logic [AW:0]   level_o;

    int            n_checks = 0;
    int            n_fails  = 0;
    int            cyc      = 0;
    logic          mon_abort = 1'b0;
    logic [7:0]    rx_q[$];
    int            rx_start_q[$];
    logic [7:0]    exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        exp_ready;
        logic [AW:0] exp_level;
    } vec_t;
    vec_t tbl [17];

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(AW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .cts_i   (cts_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic v);
        data_i  = d;
        valid_i = v;
        step(1);
    endtask

    // Receive-side decoder: samples mid-bit, independent of the transmitter internals.
    always begin : line_monitor
        logic [7:0] b;
        logic       s0;
        logic       s9;
        int         t0;
        @(negedge tx_o);
        if (!rst_i) begin
            t0 = cyc;
            repeat (DIV / 2) @(posedge clk_i);
            #1 s0 = tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk_i);
                #1 b[i] = tx_o;
            end
            repeat (DIV) @(posedge clk_i);
            #1 s9 = tx_o;
            if (!mon_abort) begin
                checkOutput("rx start bit", {31'd0, s0}, 32'd0);
                checkOutput("rx stop bit", {31'd0, s9}, 32'd1);
                rx_q.push_back(b);
                rx_start_q.push_back(t0);
            end
        end
    end

    task automatic wait_rx(input int count, input int budget);
        int t = 0;
        while (rx_q.size() < count && t < budget) begin
            step(1);
            t++;
        end
        checkOutput("rx frames within budget", {31'd0, rx_q.size() >= count}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy_o && t < budget) begin
            step(1);
            t++;
        end
        checkOutput("idle within budget", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic compare_rx(input string name, input logic contiguous);
        checkOutput({name, " frame count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkOutput({name, " byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        if (contiguous) begin
            for (int i = 1; i < rx_start_q.size(); i++) begin
                checkOutput({name, " frame spacing"}, rx_start_q[i] - rx_start_q[i-1], FRAME);
            end
        end
        rx_q.delete();
        exp_q.delete();
        rx_start_q.delete();
    endtask

    // Called right after the pop edge: every frame bit must hold for exactly DIV cycles.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step(1);
            checkOutput("frame bit first cycle", {31'd0, tx_o}, {31'd0, frame[k]});
            step(DIV - 1);
            checkOutput("frame bit last cycle", {31'd0, tx_o}, {31'd0, frame[k]});
        end
        checkOutput("busy at frame end", {31'd0, busy_o}, 32'd1);
        step(1);
        checkOutput("busy after frame", {31'd0, busy_o}, 32'd0);
        checkOutput("tx idle after frame", {31'd0, tx_o}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         n;
        int         quiet;
        logic [7:0] rb;

        rst_i   = 1'b1;
        data_i  = 8'd0;
        valid_i = 1'b0;
        cts_i   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tbl[i].data      = 8'(i);
            tbl[i].valid     = 1'b1;
            tbl[i].exp_level = (AW + 1)'((i + 1 > DEPTH) ? DEPTH : i + 1);
            tbl[i].exp_ready = (i + 1 < DEPTH);
        end
        #2;
        checkOutput("reset tx", {31'd0, tx_o}, 32'd1);
        checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset ready", {31'd0, ready_o}, 32'd1);
        checkOutput("reset level", {27'd0, level_o}, 32'd0);
        step(2);
        rst_i = 1'b0;
        cts_i = 1'b1;
        step(3);

        // Single byte: pop one edge after the write, then exact bit timing.
        exp_q.push_back(8'h55);
        applyStimulus(8'h55, 1'b1);
        checkOutput("0x55 level after write", {27'd0, level_o}, 32'd1);
        checkOutput("0x55 busy before pop", {31'd0, busy_o}, 32'd0);
        valid_i = 1'b0;
        step(1);
        checkOutput("0x55 level after pop", {27'd0, level_o}, 32'd0);
        checkOutput("0x55 busy after pop", {31'd0, busy_o}, 32'd1);
        check_frame(8'h55);
        wait_rx(1, 2 * FRAME);
        compare_rx("single 0x55", 1'b0);

        // Two bytes on consecutive cycles run as contiguous frames.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h31);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("pair level after first write", {27'd0, level_o}, 32'd1);
        applyStimulus(8'h31, 1'b1);
        valid_i = 1'b0;
        checkOutput("pair level write+pop", {27'd0, level_o}, 32'd1);
        checkOutput("pair tx start", {31'd0, tx_o}, 32'd0);
        step(FRAME - 1);
        checkOutput("pair stop bit of 0xAA", {31'd0, tx_o}, 32'd1);
        checkOutput("pair level before second pop", {27'd0, level_o}, 32'd1);
        step(1);
        checkOutput("pair level after second pop", {27'd0, level_o}, 32'd0);
        checkOutput("pair start of 0x31", {31'd0, tx_o}, 32'd0);
        step(FRAME - 1);
        checkOutput("pair busy at end", {31'd0, busy_o}, 32'd1);
        step(1);
        checkOutput("pair busy after", {31'd0, busy_o}, 32'd0);
        wait_rx(2, FRAME);
        compare_rx("pair", 1'b1);

        // CTS dropped mid-frame: current byte completes, queued byte waits.
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h42);
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h42, 1'b1);
        valid_i = 1'b0;
        step(3 * DIV);
        cts_i = 1'b0;
        step(FRAME - 3 * DIV);
        checkOutput("cts hold busy", {31'd0, busy_o}, 32'd0);
        checkOutput("cts hold level", {27'd0, level_o}, 32'd1);
        step(3 * DIV);
        checkOutput("cts hold tx", {31'd0, tx_o}, 32'd1);
        checkOutput("cts hold level later", {27'd0, level_o}, 32'd1);
        cts_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (!busy_o) step(1);
        end
        checkOutput("cts restart within 3 cycles", {31'd0, busy_o}, 32'd1);
        checkOutput("cts restart level", {27'd0, level_o}, 32'd0);
        wait_idle(2 * FRAME);
        wait_rx(2, FRAME);
        compare_rx("cts pause", 1'b0);

        // Fill with CTS low: 17th byte dropped, then a write coincident with the first pop.
        cts_i = 1'b0;
        step(3);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].data, tbl[i].valid);
            checkOutput("fill level", {27'd0, level_o}, {27'd0, tbl[i].exp_level});
            checkOutput("fill ready", {31'd0, ready_o}, {31'd0, tbl[i].exp_ready});
            checkOutput("fill tx idle", {31'd0, tx_o}, 32'd1);
            if (i < DEPTH) exp_q.push_back(tbl[i].data);
        end
        data_i = 8'h77;
        cts_i  = 1'b1;
        step(1);
        checkOutput("full write ignored level", {27'd0, level_o}, 32'd16);
        step(1);
        checkOutput("full write ignored level 2", {27'd0, level_o}, 32'd16);
        step(1);
        valid_i = 1'b0;
        checkOutput("full write+pop level", {27'd0, level_o}, 32'd16);
        checkOutput("full write+pop busy", {31'd0, busy_o}, 32'd1);
        checkOutput("full ready after write+pop", {31'd0, ready_o}, 32'd0);
        exp_q.push_back(8'h77);
        wait_idle(18 * FRAME);
        checkOutput("drain level", {27'd0, level_o}, 32'd0);
        checkOutput("drain ready", {31'd0, ready_o}, 32'd1);
        wait_rx(17, FRAME);
        compare_rx("full drain", 1'b1);

        // Reset during data bit 3 of 0xAA with two bytes queued.
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        applyStimulus(8'hCC, 1'b1);
        valid_i = 1'b0;
        checkOutput("abort queued level", {27'd0, level_o}, 32'd2);
        step(4 * DIV + 1);
        checkOutput("abort in bit 3", {31'd0, tx_o}, 32'd1);
        mon_abort = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        checkOutput("async reset tx", {31'd0, tx_o}, 32'd1);
        checkOutput("async reset level", {27'd0, level_o}, 32'd0);
        checkOutput("async reset busy", {31'd0, busy_o}, 32'd0);
        checkOutput("async reset ready", {31'd0, ready_o}, 32'd1);
        #2 rst_i = 1'b0;
        quiet = 1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) quiet = 0;
        end
        checkOutput("quiet after reset", quiet, 1);
        checkOutput("level after reset", {27'd0, level_o}, 32'd0);
        mon_abort = 1'b0;
        compare_rx("after reset", 1'b0);

        // Random streams with random CTS toggling; never more than a FIFO's worth queued.
        for (int r = 0; r < 4; r++) begin
            n     = $urandom_range(1, DEPTH);
            cts_i = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                quiet = $urandom_range(0, 3);
                if (quiet > 0) step(quiet);
                if ($urandom_range(0, 3) == 0) cts_i = ~cts_i;
                checkOutput("random ready", {31'd0, ready_o}, 32'd1);
                rb = 8'($urandom);
                exp_q.push_back(rb);
                applyStimulus(rb, 1'b1);
                valid_i = 1'b0;
            end
            cts_i = 1'b1;
            wait_rx(n, (n + 2) * FRAME);
            wait_idle(2 * FRAME);
            checkOutput("random level drained", {27'd0, level_o}, 32'd0);
            compare_rx("random", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
